// File: rtl/config_bitstream_loader.sv
// config_bitstream_loader
//   Serialises a word-oriented configuration bitstream onto the config chain
//   (cen / shift_in / set_in) that threads through a column of slice config
//   tiles. Words arrive over a valid/ready port, bit 0 first. Exactly CHAIN_LEN
//   bits are shifted. set_in is then held for SET_CYC cycles so that every tile
//   latches its configuration at the same time.
//
// Optional feature: define CFG_READBACK_EN to collect chain_out, LSB first, on
//   every shift cycle and return it word by word on rb_valid / rb_data. This
//   yields the chain contents from before the current load. When the macro is
//   undefined, chain_out is unused and rb_valid / rb_data are tied to zero.
//
// Ports
//   clk, rst_n            fabric clock, asynchronous active-low reset
//   start, abort          begin a load (sampled in IDLE), abandon a load
//   word_valid/_ready     bitstream word handshake, word_data LSB shifted first
//   busy, done            load in progress, one-cycle completion pulse
//   cen, shift_in, set_in registered config chain drive
//   chain_out             serial data returning from the last tile
//   rb_valid, rb_data     readback words (CFG_READBACK_EN only)
module config_bitstream_loader #(
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned CHAIN_LEN = 143,
  parameter int unsigned SET_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  output logic              busy,
  output logic              done,
  output logic              cen,
  output logic              shift_in,
  output logic              set_in,
  input  logic              chain_out,
  output logic              rb_valid,
  output logic [WORD_W-1:0] rb_data
);

  localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BitW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned SetW  = (SET_CYC > 1) ? $clog2(SET_CYC) : 1;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(CHAIN_LEN - 1);
  localparam logic [BitW-1:0]  BitLast = BitW'(WORD_W - 1);
  localparam logic [SetW-1:0]  SetLast = SetW'(SET_CYC - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StShift, StSet, StDone} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;        // bits shifted in this load
  logic [BitW-1:0]   bit_q, bit_d;        // bit index within the current word
  logic [SetW-1:0]   set_cnt_q, set_cnt_d;
  logic              cen_q, cen_d;
  logic              shift_in_q, shift_in_d;
  logic              set_in_q, set_in_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Abort is combinational here so that a word is never handshaken in the
  // cycle in which the load is being abandoned.
  assign word_ready = (state_q == StFetch) & ~abort;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    set_cnt_d = set_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFetch;
          cnt_d   = '0;
        end
      end
      StFetch: begin
        if (word_valid) begin
          sreg_d  = word_data;
          bit_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        bit_d  = bit_q + BitW'(1);
        // The chain length takes priority: leftover bits of the last word are dropped.
        if (cnt_q == CntLast) begin
          state_d   = StSet;
          set_cnt_d = '0;
        end else if (bit_q == BitLast) begin
          state_d = StFetch;
        end
      end
      StSet: begin
        set_cnt_d = set_cnt_q + SetW'(1);
        if (set_cnt_q == SetLast) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
    end

    // Outputs are registered copies of the next-state decode, so each one is
    // high in exactly the cycles that the FSM spends in the matching state.
    cen_d      = (state_d == StShift);
    shift_in_d = cen_d & sreg_d[0];
    set_in_d   = (state_d == StSet);
    done_d     = (state_d == StDone);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sreg_q     <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      set_cnt_q  <= '0;
      cen_q      <= 1'b0;
      shift_in_q <= 1'b0;
      set_in_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sreg_q     <= sreg_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      set_cnt_q  <= set_cnt_d;
      cen_q      <= cen_d;
      shift_in_q <= shift_in_d;
      set_in_q   <= set_in_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign cen      = cen_q;
  assign shift_in = shift_in_q;
  assign set_in   = set_in_q;
  assign done     = done_q;
  assign busy     = busy_q;

`ifdef CFG_READBACK_EN
  logic [WORD_W-1:0] rb_col_q, rb_col_d;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              rb_valid_q, rb_valid_d;

  // chain_out is the bit leaving the last tile on the same edge that shifts
  // ours in, so sampling it on shift cycles returns the previous contents.
  always_comb begin
    rb_col_d   = rb_col_q;
    rb_data_d  = '0;
    rb_valid_d = 1'b0;
    if (state_q == StShift) begin
      rb_col_d[bit_q] = chain_out;
      if ((cnt_q == CntLast) || (bit_q == BitLast)) begin
        rb_valid_d = 1'b1;
        rb_data_d  = rb_col_d;
        rb_col_d   = '0;
      end
    end
    if (abort) begin
      rb_col_d   = '0;
      rb_valid_d = 1'b0;
      rb_data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_col_q   <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_col_q   <= rb_col_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;
`else
  logic unused_chain_out;
  assign unused_chain_out = chain_out;
  assign rb_valid         = 1'b0;
  assign rb_data          = '0;
`endif

endmodule
